seg7_scan_mux: RTL and testbench

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_scan_mux.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment driver with a per-slot ghosting blank and frame-atomic updates.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg7_scan_mux #(
    parameter int unsigned DWELL        = 100,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [6:0]  led_out,
    output logic        dp_out,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]       SEG_OFF   = 7'b1111111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      active_q, active_d;
    logic [3:0]       active_dp_q, active_dp_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic             pending_q, pending_d;
    logic [6:0]       led_q, led_d;
    logic             dp_q, dp_d;
    logic [3:0]       digit_en_q, digit_en_d;
    logic             frame_done_q, frame_done_d;

    logic             apply_c;
    logic             off_c;
    logic             lz_blank_c;
    logic [3:0]       nibble_c;

    // BCD to active-low a..g; non-decimal codes light nothing.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] seg;
        unique case (n)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Scan sequencing, shadow/active update, and outputs aligned to the next scan position.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        led_d        = SEG_OFF;
        dp_d         = 1'b0;
        digit_en_d   = 4'b0000;
        frame_done_d = 1'b0;
        lz_blank_c   = 1'b0;
        nibble_c     = 4'd0;

        apply_c = (idx_q == 2'd3) && (cnt_q == CNT_LAST);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end

        // A load landing on the apply edge bypasses the shadow entirely.
        if (apply_c) begin
            if (load) begin
                active_d    = value;
                active_dp_d = dp_in;
            end else if (pending_q) begin
                active_d    = shadow_q;
                active_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end

        nibble_c = active_d[{idx_d, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        unique case (idx_d)
            2'd3:    lz_blank_c = (active_d[15:12] == 4'd0);
            2'd2:    lz_blank_c = (active_d[15:8]  == 8'd0);
            2'd1:    lz_blank_c = (active_d[15:4]  == 12'd0);
            default: lz_blank_c = 1'b0;
        endcase
        lz_blank_c = lz_blank_c && !active_dp_d[idx_d];
`else
        lz_blank_c = 1'b0;
`endif

        off_c = (cnt_d < CNT_BLANK) || lz_blank_c;

        if (!off_c) begin
            digit_en_d = 4'(4'b0001 << idx_d);
            led_d      = decode(nibble_c);
            dp_d       = active_dp_d[idx_d];
        end

        frame_done_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            active_q     <= 16'h0000;
            active_dp_q  <= 4'b0000;
            shadow_q     <= 16'h0000;
            shadow_dp_q  <= 4'b0000;
            pending_q    <= 1'b0;
            led_q        <= SEG_OFF;
            dp_q         <= 1'b0;
            digit_en_q   <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            led_q        <= led_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led_out    = led_q;
    assign dp_out     = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux at DWELL=8, BLANK_CYCLES=2; honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_mux;

    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * DWELL;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  led_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_done;

    int errors;
    int checks;
    int t;

    seg7_scan_mux #(.DWELL(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .led_out    (led_out),
        .dp_out     (dp_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_off(input string tag);
        check_eq({tag, " digit_en"},   16'(digit_en),   16'h0);
        check_eq({tag, " led_out"},    16'(led_out),    16'h7f);
        check_eq({tag, " dp_out"},     16'(dp_out),     16'h0);
        check_eq({tag, " frame_done"}, 16'(frame_done), 16'h0);
    endtask

    // Steps n cycles; segs = {d3,d2,d1,d0} patterns, mask = digits expected dark for the whole slot.
    task automatic run_check(input int n, input logic [27:0] segs, input logic [3:0] dpx,
                             input logic [3:0] mask);
        int         cnt;
        int         idx;
        logic [3:0] exp_en;
        logic [6:0] exp_led;
        logic       exp_dp;
        logic       exp_fd;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            t++;
            load = 1'b0;
            cnt  = t % DWELL;
            idx  = (t / DWELL) % 4;
            if (cnt < BLANK || mask[idx]) begin
                exp_en  = 4'b0000;
                exp_led = SX;
                exp_dp  = 1'b0;
            end else begin
                exp_en  = 4'(4'b0001 << idx);
                exp_led = segs[idx*7 +: 7];
                exp_dp  = dpx[idx];
            end
            exp_fd = ((t % FRAME) == FRAME - 1);
            check_eq($sformatf("t%0d digit_en", t),   16'(digit_en),   16'(exp_en));
            check_eq($sformatf("t%0d led_out", t),    16'(led_out),    16'(exp_led));
            check_eq($sformatf("t%0d dp_out", t),     16'(dp_out),     16'(exp_dp));
            check_eq($sformatf("t%0d frame_done", t), 16'(frame_done), 16'(exp_fd));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        t      = 0;
        reset  = 1'b1;
        load   = 1'b0;
        value  = 16'h0000;
        dp_in  = 4'b0000;

        repeat (2) @(negedge clk);
        check_off("reset");
        reset = 1'b0;

        // Load 1234 at the start of the first frame; it must wait for the apply edge.
        load  = 1'b1;
        value = 16'h1234;
        run_check(31, {S0, S0, S0, S0}, 4'b0000, LZ ? 4'b1110 : 4'b0000);
        run_check(32, {S1, S2, S3, S4}, 4'b0000, 4'b0000);

        // Two loads mid-frame: last one wins, current frame stays untouched.
        run_check(10, {S1, S2, S3, S4}, 4'b0000, 4'b0000);
        load  = 1'b1;
        value = 16'hABCD;
        run_check(2, {S1, S2, S3, S4}, 4'b0000, 4'b0000);
        load  = 1'b1;
        value = 16'h5678;
        run_check(20, {S1, S2, S3, S4}, 4'b0000, 4'b0000);
        run_check(32, {S5, S6, S7, S8}, 4'b0000, 4'b0000);

        // Load on the apply edge goes straight to the display.
        load  = 1'b1;
        value = 16'h00F5;
        dp_in = 4'b0000;
        run_check(3, {S0, S0, SX, S5}, 4'b0000, LZ ? 4'b1100 : 4'b0000);
        load  = 1'b1;
        value = 16'h0045;
        run_check(29, {S0, S0, SX, S5}, 4'b0000, LZ ? 4'b1100 : 4'b0000);
        run_check(32, {S0, S0, S4, S5}, 4'b0000, LZ ? 4'b1100 : 4'b0000);

        // Decimal point on digit 2 protects it from leading-zero blanking.
        load  = 1'b1;
        value = 16'h0045;
        dp_in = 4'b0110;
        run_check(32, {S0, S0, S4, S5}, 4'b0110, LZ ? 4'b1000 : 4'b0000);

        // Pending value discarded by a mid-scan reset that coincides with a load.
        run_check(7, {S0, S0, S4, S5}, 4'b0110, LZ ? 4'b1000 : 4'b0000);
        load  = 1'b1;
        value = 16'h9876;
        dp_in = 4'b1111;
        run_check(13, {S0, S0, S4, S5}, 4'b0110, LZ ? 4'b1000 : 4'b0000);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        check_off("midreset");
        reset = 1'b0;
        load  = 1'b0;
        t     = 0;
        run_check(64, {S0, S0, S0, S0}, 4'b0000, LZ ? 4'b1110 : 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
